// File: rtl/seven_seg_scroll_controller.sv
// seven_seg_scroll_controller
//
// Drives a memory-mapped 8-digit seven-segment display (digit registers at
// BASE_ADDR+0..7). A message buffer of glyph codes is rewritten into the 8
// digit registers once per frame, and the window slides one position per
// scroll step. The CPU shares the display write bus and always wins: while
// cpu_req is high the scroller stalls in place.
//
// Optional build macro:
//   SEVEN_SEG_SCROLL_BLANK_PAD_EN - message wraps at len+8 and positions past
//   the end show blank (code 20), so the text scrolls fully off before it
//   reappears.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   msg_we/waddr/wdata message buffer write port (any state)
//   msg_len           message length, latched on start (1..MSG_DEPTH valid)
//   start, stop       control pulses; stop wins over start
//   cpu_req/addr/data CPU write request to the display bus
//   cpu_gnt           always equal to cpu_req
//   addressbusHigh/Low, databus, writeEnable  registered display bus
//   busy              high whenever not idle
//   frame_done        pulse coincident with the digit-7 bus write
module seven_seg_scroll_controller #(
  parameter int          MSG_DEPTH = 32,
  parameter int          TICK_DIV  = 1000000,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         msg_we,
  input  logic [$clog2(MSG_DEPTH)-1:0] msg_waddr,
  input  logic [7:0]                   msg_wdata,
  input  logic [$clog2(MSG_DEPTH):0]   msg_len,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         cpu_req,
  input  logic [15:0]                  cpu_addr,
  input  logic [7:0]                   cpu_data,
  output logic                         cpu_gnt,
  output logic [7:0]                   addressbusHigh,
  output logic [7:0]                   addressbusLow,
  output logic [7:0]                   databus,
  output logic                         writeEnable,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REFRESH, ST_WAIT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    msg_q [MSG_DEPTH];
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] offset_q, offset_d;
  logic [2:0]    digit_q, digit_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          we_q, we_d;
  logic          fd_q, fd_d;

  logic          len_ok;
  logic          scr_we;
  logic          last_digit;
  logic          tick_end;
  logic [LW:0]   wrap_w;
  logic [LW:0]   ptr_inc;
  logic [LW:0]   offset_inc;
  logic [LW-1:0] ptr_nxt;
  logic [LW-1:0] offset_nxt;
  logic [7:0]    glyph;

  assign len_ok     = (msg_len != '0) && (msg_len <= LW'(MSG_DEPTH));
  assign last_digit = (digit_q == 3'd7);
  assign tick_end   = (tick_q == TW'(TICK_DIV - 1));
  // The scroller only drives the bus when the CPU is absent and no stop is
  // pending; a stop suppresses the write issued in the same cycle.
  assign scr_we     = (state_q == ST_REFRESH) && !cpu_req && !stop;

`ifdef SEVEN_SEG_SCROLL_BLANK_PAD_EN
  // Eight padding positions after the message scroll it fully off-screen.
  assign wrap_w = {1'b0, len_q} + (LW+1)'(8);
  assign glyph  = (ptr_q < len_q) ? msg_q[ptr_q[AW-1:0]] : 8'd20;
`else
  assign wrap_w = {1'b0, len_q};
  assign glyph  = msg_q[ptr_q[AW-1:0]];
`endif

  assign ptr_inc    = {1'b0, ptr_q} + (LW+1)'(1);
  assign offset_inc = {1'b0, offset_q} + (LW+1)'(1);
  assign ptr_nxt    = (ptr_inc == wrap_w) ? '0 : ptr_inc[LW-1:0];
  assign offset_nxt = (offset_inc == wrap_w) ? '0 : offset_inc[LW-1:0];

  assign cpu_gnt        = cpu_req;
  assign busy           = (state_q != ST_IDLE);
  assign addressbusHigh = addr_q[15:8];
  assign addressbusLow  = addr_q[7:0];
  assign databus        = data_q;
  assign writeEnable    = we_q;
  assign frame_done     = fd_q;

  // Message buffer: not reset, written from any state.
  always_ff @(posedge clk) begin
    if (msg_we) msg_q[msg_waddr] <= msg_wdata;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start && !stop && len_ok) state_d = ST_REFRESH;
      ST_REFRESH: if (stop) state_d = ST_IDLE;
                  else if (scr_we && last_digit) state_d = ST_WAIT;
      ST_WAIT:    if (stop) state_d = ST_IDLE;
                  else if (tick_end) state_d = ST_REFRESH;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Scroll position, tick counter and bus mux
  always_comb begin
    len_d    = len_q;
    ptr_d    = ptr_q;
    offset_d = offset_q;
    digit_d  = digit_q;
    tick_d   = tick_q;
    if (stop) begin
      offset_d = '0;
      digit_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start && len_ok) begin
          len_d    = msg_len;
          offset_d = '0;
          digit_d  = '0;
          ptr_d    = '0;
        end
        ST_REFRESH: if (!cpu_req) begin
          digit_d = digit_q + 3'd1;
          ptr_d   = ptr_nxt;
          if (last_digit) tick_d = '0;
        end
        ST_WAIT: begin
          // Free-running during WAIT: CPU traffic does not delay the scroll.
          tick_d = tick_q + TW'(1);
          if (tick_end) begin
            offset_d = offset_nxt;
            digit_d  = '0;
            ptr_d    = offset_nxt;
          end
        end
        default: ;
      endcase
    end

    // Idle bus keeps its last address/data, only the strobe drops.
    addr_d = addr_q;
    data_d = data_q;
    we_d   = 1'b0;
    fd_d   = 1'b0;
    if (cpu_req) begin
      addr_d = cpu_addr;
      data_d = cpu_data;
      we_d   = 1'b1;
    end else if (scr_we) begin
      addr_d = BASE_ADDR + {13'd0, digit_q};
      data_d = glyph;
      we_d   = 1'b1;
      fd_d   = last_digit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      ptr_q    <= '0;
      offset_q <= '0;
      digit_q  <= '0;
      tick_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      len_q    <= len_d;
      ptr_q    <= ptr_d;
      offset_q <= offset_d;
      digit_q  <= digit_d;
      tick_q   <= tick_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      fd_q     <= fd_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scroll_controller.sv
module tb_seven_seg_scroll_controller;

  localparam int          MSG_DEPTH = 16;
  localparam int          TICK_DIV  = 4;
  localparam logic [15:0] BASE_ADDR = 16'h0A00;
  localparam int          AW        = $clog2(MSG_DEPTH);

  logic              clk = 1'b0;
  logic              rst, msg_we, start, stop, cpu_req;
  logic [AW-1:0]     msg_waddr;
  logic [7:0]        msg_wdata, cpu_data;
  logic [AW:0]       msg_len;
  logic [15:0]       cpu_addr;
  logic              cpu_gnt, writeEnable, busy, frame_done;
  logic [7:0]        addressbusHigh, addressbusLow, databus;

  seven_seg_scroll_controller #(
    .MSG_DEPTH(MSG_DEPTH), .TICK_DIV(TICK_DIV), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .msg_we(msg_we), .msg_waddr(msg_waddr),
    .msg_wdata(msg_wdata), .msg_len(msg_len), .start(start), .stop(stop),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_gnt(cpu_gnt), .addressbusHigh(addressbusHigh),
    .addressbusLow(addressbusLow), .databus(databus),
    .writeEnable(writeEnable), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic        fd;
  } wr_t;

  wr_t        log_q[$];
  wr_t        exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m [MSG_DEPTH];

  function automatic wr_t mk_wr(int c, logic [15:0] a, logic [7:0] d, logic w, logic f);
    wr_t e;
    e.cyc = c; e.addr = a; e.data = d; e.we = w; e.fd = f;
    return e;
  endfunction

  // Bus monitor: every cycle with a write strobe or a frame_done pulse.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (writeEnable === 1'b1 || frame_done === 1'b1)
      log_q.push_back(mk_wr(cyc, {addressbusHigh, addressbusLow}, databus, writeEnable, frame_done));
  end

  // Reference: after s scroll steps digit d shows message position (s+d)
  // modulo the scroll period; positions past the message are blank.
  function automatic logic [7:0] model_glyph(int len, int s, int d);
    int p, pos;
`ifdef SEVEN_SEG_SCROLL_BLANK_PAD_EN
    p = len + 8;
`else
    p = len;
`endif
    pos = (s + d) % p;
    return (pos < len) ? m[pos] : 8'd20;
  endfunction

  // Expected frames; cyc is relative to the first expected write. Frames are
  // 8 consecutive writes, and the next frame starts TICK_DIV+1 cycles after
  // the digit-7 write.
  task automatic build_frames(int len, int s0, int nf, int rel0);
    for (int f = 0; f < nf; f++)
      for (int d = 0; d < 8; d++)
        exp_q.push_back(mk_wr(rel0 + f * (8 + TICK_DIV) + d, BASE_ADDR + 16'(d),
                              model_glyph(len, s0 + f, d), 1'b1, d == 7));
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_msg(int idx, logic [7:0] v);
    msg_we = 1'b1; msg_waddr = AW'(idx); msg_wdata = v;
    tick();
    msg_we = 1'b0;
    m[idx] = v;
  endtask

  task automatic load_seq(int n, int first);
    for (int i = 0; i < n; i++) write_msg(i, 8'(first + i));
  endtask

  task automatic start_scroll(int len);
    msg_len = (AW+1)'(len); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_scroll();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(2);
  endtask

  task automatic wait_writes(int n, int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if ({addressbusHigh, addressbusLow, databus, writeEnable, busy, frame_done, cpu_gnt} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h data=%h we=%b busy=%b fd=%b gnt=%b, required all 0",
               {addressbusHigh, addressbusLow}, databus, writeEnable, busy, frame_done, cpu_gnt);
    end
    rst = 1'b0;
    log_q.delete();
    tick(10);
    checks++;
    if (log_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got %0d writes busy=%b, required 0 writes busy=0", log_q.size(), busy);
    end
  endtask

  task automatic test_basic_frame();
    int c0;
    load_seq(10, 0);
    log_q.delete(); exp_q.delete();
    start_scroll(10);
    c0 = cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy: got %b, required 1", busy);
    end
    build_frames(10, 0, 2, 0);
    wait_writes(16, 80);
    checks++;
    if (log_q.size() < 16) begin
      errors++; $display("FAIL basic_count: got %0d writes, required 16", log_q.size());
    end else begin
      checks++;
      if (log_q[0].cyc !== c0 + 1) begin
        errors++; $display("FAIL basic_latency: got first write at %0d, required %0d", log_q[0].cyc, c0 + 1);
      end
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].addr !== exp_q[i].addr || log_q[i].data !== exp_q[i].data || log_q[i].we !== 1'b1 ||
          log_q[i].fd !== exp_q[i].fd || log_q[i].cyc - log_q[0].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL basic_wr[%0d]: got addr=%h data=%0d fd=%b dcyc=%0d, required addr=%h data=%0d fd=%b dcyc=%0d",
                 i, log_q[i].addr, log_q[i].data, log_q[i].fd, log_q[i].cyc - log_q[0].cyc,
                 exp_q[i].addr, exp_q[i].data, exp_q[i].fd, exp_q[i].cyc);
      end
    end
    stop_scroll();
  endtask

  // Runs nf frames of a len-entry message (already loaded) and checks them.
  task automatic test_scroll(string name, int len, int nf);
    log_q.delete(); exp_q.delete();
    start_scroll(len);
    build_frames(len, 0, nf, 0);
    wait_writes(nf * 8, nf * (8 + TICK_DIV) + 40);
    checks++;
    if (log_q.size() < nf * 8) begin
      errors++; $display("FAIL %s_count: got %0d writes, required %0d", name, log_q.size(), nf * 8);
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].addr !== exp_q[i].addr || log_q[i].data !== exp_q[i].data || log_q[i].we !== 1'b1 ||
          log_q[i].fd !== exp_q[i].fd || log_q[i].cyc - log_q[0].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL %s_wr[%0d]: got addr=%h data=%0d fd=%b dcyc=%0d, required addr=%h data=%0d fd=%b dcyc=%0d",
                 name, i, log_q[i].addr, log_q[i].data, log_q[i].fd, log_q[i].cyc - log_q[0].cyc,
                 exp_q[i].addr, exp_q[i].data, exp_q[i].fd, exp_q[i].cyc);
      end
    end
    stop_scroll();
  endtask

  task automatic test_scroll_wrap();
    load_seq(10, 0);
    test_scroll("wrap", 10, 11);
  endtask

  task automatic test_short_msg();
    load_seq(3, 16);
    test_scroll("short", 3, 12);
    load_seq(3, 0);
    test_scroll("short0", 3, 4);
  endtask

  task automatic test_random_scroll();
    int len;
    for (int it = 0; it < 3; it++) begin
      len = $urandom_range(1, MSG_DEPTH);
      for (int i = 0; i < len; i++) write_msg(i, 8'($urandom_range(0, 31)));
      test_scroll("rand", len, len + 9);
    end
  endtask

  task automatic test_cpu_priority();
    load_seq(10, 0);
    log_q.delete(); exp_q.delete();
    start_scroll(10);
    tick(3);
    cpu_req = 1'b1; cpu_addr = 16'h0005; cpu_data = 8'd12;
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++; $display("FAIL cpu_gnt: got %b, required 1", cpu_gnt);
    end
    tick(2);
    cpu_req = 1'b0;
    tick(5);
    // CPU traffic during WAIT must not delay the next frame.
    cpu_req = 1'b1; cpu_addr = 16'h0006; cpu_data = 8'd3;
    tick(2);
    cpu_req = 1'b0;
    for (int d = 0; d < 3; d++) exp_q.push_back(mk_wr(d, BASE_ADDR + 16'(d), m[d], 1'b1, 1'b0));
    exp_q.push_back(mk_wr(3, 16'h0005, 8'd12, 1'b1, 1'b0));
    exp_q.push_back(mk_wr(4, 16'h0005, 8'd12, 1'b1, 1'b0));
    for (int d = 3; d < 8; d++) exp_q.push_back(mk_wr(d + 2, BASE_ADDR + 16'(d), model_glyph(10, 0, d), 1'b1, d == 7));
    exp_q.push_back(mk_wr(10, 16'h0006, 8'd3, 1'b1, 1'b0));
    exp_q.push_back(mk_wr(11, 16'h0006, 8'd3, 1'b1, 1'b0));
    build_frames(10, 1, 1, 9 + TICK_DIV + 1);
    wait_writes(20, 60);
    checks++;
    if (log_q.size() < 20) begin
      errors++; $display("FAIL cpu_count: got %0d writes, required 20", log_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].addr !== exp_q[i].addr || log_q[i].data !== exp_q[i].data || log_q[i].we !== 1'b1 ||
          log_q[i].fd !== exp_q[i].fd || log_q[i].cyc - log_q[0].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL cpu_wr[%0d]: got addr=%h data=%0d fd=%b dcyc=%0d, required addr=%h data=%0d fd=%b dcyc=%0d",
                 i, log_q[i].addr, log_q[i].data, log_q[i].fd, log_q[i].cyc - log_q[0].cyc,
                 exp_q[i].addr, exp_q[i].data, exp_q[i].fd, exp_q[i].cyc);
      end
    end
    stop_scroll();
  endtask

  task automatic test_stop();
    load_seq(10, 0);
    // Stop while digit 4 is due, together with a CPU write.
    log_q.delete(); exp_q.delete();
    start_scroll(10);
    tick(4);
    stop = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h00F0; cpu_data = 8'h05;
    tick();
    stop = 1'b0; cpu_req = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL stop_busy: got %b, required 0", busy);
    end
    tick(20);
    for (int d = 0; d < 4; d++) exp_q.push_back(mk_wr(d, BASE_ADDR + 16'(d), m[d], 1'b1, 1'b0));
    exp_q.push_back(mk_wr(4, 16'h00F0, 8'h05, 1'b1, 1'b0));
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stop_count: got %0d writes, required %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].addr !== exp_q[i].addr || log_q[i].data !== exp_q[i].data ||
          log_q[i].fd !== exp_q[i].fd || log_q[i].cyc - log_q[0].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL stop_wr[%0d]: got addr=%h data=%0d fd=%b dcyc=%0d, required addr=%h data=%0d fd=%b dcyc=%0d",
                 i, log_q[i].addr, log_q[i].data, log_q[i].fd, log_q[i].cyc - log_q[0].cyc,
                 exp_q[i].addr, exp_q[i].data, exp_q[i].fd, exp_q[i].cyc);
      end
    end
    // Stop during WAIT: nothing further appears.
    log_q.delete();
    start_scroll(10);
    wait_writes(8, 40);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick(30);
    checks++;
    if (log_q.size() != 8 || busy !== 1'b0) begin
      errors++; $display("FAIL stop_wait: got %0d writes busy=%b, required 8 writes busy=0", log_q.size(), busy);
    end
  endtask

  task automatic test_start_edges();
    int bad_len [2] = '{0, MSG_DEPTH + 1};
    for (int k = 0; k < 2; k++) begin
      log_q.delete();
      start_scroll(bad_len[k]);
      tick(10);
      checks++;
      if (busy !== 1'b0 || log_q.size() != 0) begin
        errors++;
        $display("FAIL start_badlen%0d: got busy=%b writes=%0d, required busy=0 writes=0", bad_len[k], busy, log_q.size());
      end
    end
    msg_len = (AW+1)'(10); start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_stop_same: got busy=%b, required 0", busy);
    end
    start_scroll(MSG_DEPTH);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL start_maxlen: got busy=%b, required 1", busy);
    end
    stop_scroll();
    // A second start while running must not relatch the length.
    load_seq(10, 0);
    log_q.delete(); exp_q.delete();
    start_scroll(10);
    tick(2);
    start_scroll(3);
    build_frames(10, 0, 2, 0);
    wait_writes(16, 80);
    checks++;
    if (log_q.size() < 16) begin
      errors++; $display("FAIL restart_count: got %0d writes, required 16", log_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].addr !== exp_q[i].addr || log_q[i].data !== exp_q[i].data ||
          log_q[i].fd !== exp_q[i].fd || log_q[i].cyc - log_q[0].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL restart_wr[%0d]: got addr=%h data=%0d dcyc=%0d, required addr=%h data=%0d dcyc=%0d",
                 i, log_q[i].addr, log_q[i].data, log_q[i].cyc - log_q[0].cyc,
                 exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    stop_scroll();
  endtask

  task automatic test_reset_mid_frame();
    load_seq(10, 0);
    log_q.delete();
    start_scroll(10);
    tick(3);
    rst = 1'b1;
    tick();
    checks++;
    if ({addressbusHigh, addressbusLow, databus, writeEnable, busy, frame_done} !== 27'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got addr=%h data=%h we=%b busy=%b fd=%b, required all 0",
               {addressbusHigh, addressbusLow}, databus, writeEnable, busy, frame_done);
    end
    rst = 1'b0;
    tick(20);
    checks++;
    if (log_q.size() != 3) begin
      errors++; $display("FAIL midreset_count: got %0d writes, required 3", log_q.size());
    end
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i].addr !== BASE_ADDR + 16'(i) || log_q[i].data !== m[i]) begin
        errors++;
        $display("FAIL midreset_wr[%0d]: got addr=%h data=%0d, required addr=%h data=%0d",
                 i, log_q[i].addr, log_q[i].data, BASE_ADDR + 16'(i), m[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; msg_we = 1'b0; msg_waddr = '0; msg_wdata = '0; msg_len = '0;
    start = 1'b0; stop = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
    test_reset();
    test_basic_frame();
    test_scroll_wrap();
    test_short_msg();
    test_random_scroll();
    test_cpu_priority();
    test_stop();
    test_start_edges();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scroll_controller.md
Name: seven_seg_scroll_controller

Overview:
- Sequencer and bus arbiter for the memory-mapped seven-segment display peripheral (8 digit registers at BASE_ADDR+0..7; each data byte is a glyph code 0..19, and codes of 20 or more display blank).
- Holds a message buffer and periodically rewrites all 8 digit registers, shifting the message one position per scroll tick.
- The CPU can take the display write bus at any time; the CPU always has priority and the scroller stalls while the CPU holds the bus.

Parameters:
- MSG_DEPTH, 32: message buffer entries (8-bit); power of two, minimum 8.
- TICK_DIV, 1000000: clk cycles between the end of one frame and the next scroll step; minimum 1.
- BASE_ADDR, 16'h0000: address of digit 0 on the display bus.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- msg_we  in  1  message buffer write strobe.
- msg_waddr  in  $clog2(MSG_DEPTH)  message buffer write index.
- msg_wdata  in  8  glyph code to store.
- msg_len  in  $clog2(MSG_DEPTH)+1  message length; latched on start.
- start  in  1  begin scrolling (pulse).
- stop  in  1  abort and go idle (pulse).
- cpu_req  in  1  CPU requests the display bus this cycle.
- cpu_addr  in  16  CPU write address.
- cpu_data  in  8  CPU write data.
- cpu_gnt  out  1  equals cpu_req (combinational); CPU write is always accepted.
- addressbusHigh  out  8  display bus address[15:8], registered.
- addressbusLow  out  8  display bus address[7:0], registered.
- databus  out  8  display bus data, registered.
- writeEnable  out  1  display bus write strobe, registered.
- busy  out  1  1 when state is not IDLE.
- frame_done  out  1  one-cycle pulse, registered; asserted the cycle the digit-7 write appears on the bus.

Behaviour:
- Reset: state IDLE; all bus outputs 0; busy=0; frame_done=0; offset=0; digit=0; tick counter=0. Message buffer contents are not reset.
- Buffer write: any cycle, any state. A write to an entry takes effect for reads from the next cycle onward.
- States: IDLE, REFRESH, WAIT.
- IDLE:
  - start with 1 <= msg_len <= MSG_DEPTH: latch len, set offset=0, digit=0, ptr=0, go to REFRESH.
  - start with msg_len=0 or msg_len>MSG_DEPTH: ignored; stay in IDLE.
- REFRESH, cycle without cpu_req:
  - Issue a write: address=BASE_ADDR+digit, data=msg[ptr], writeEnable=1. Outputs are registered, so the write appears one cycle later.
  - Then digit+1, and ptr+1 wrapping to 0 at len.
  - After the digit=7 write: clear the tick counter and go to WAIT.
- REFRESH, cycle with cpu_req: digit and ptr hold; the scroller issues no write that cycle.
- WAIT:
  - Tick counter increments each cycle.
  - At TICK_DIV-1: offset+1, wrapping to 0 at len; digit=0; ptr=new offset; go to REFRESH.
  - cpu_req does not pause the tick counter.
- Bus mux, registered with one-cycle latency:
  - cpu_req=1: the next cycle's outputs are cpu_addr, cpu_data, writeEnable=1.
  - No CPU and no scroller write: writeEnable=0, address and data hold their last values.
- stop, any state: go to IDLE next cycle. A write already issued that cycle by the scroller is suppressed, so no scroller writes appear after the stop. offset and digit are cleared. A CPU write in the same cycle still goes out.
- start while busy: ignored.
- start and stop in the same cycle: stop wins.
- Reset mid-frame: returns to the reset state; the partially written frame is left on the display.
- len < 8: ptr wraps repeatedly, so the message repeats across the 8 digits.

Optional Feature:
- Macro: SEVEN_SEG_SCROLL_BLANK_PAD_EN.
- Defined:
  - ptr and offset wrap at len+8 instead of len.
  - Positions ptr >= len output the blank code 8'd20, giving 8 blanks between repeats so the message scrolls fully off before reappearing.
- Not defined: plain wrap at len; no blank padding.

Test Plan:
- Reset then idle: rst held 2 cycles -> all outputs 0, busy=0; cpu_req=0 for 10 cycles -> writeEnable stays 0.
- Basic frame: load msg[0..9]=0..9, msg_len=10, start, TICK_DIV=4 -> writes (addr 0..7, data 0..7) on consecutive cycles, frame_done with digit 7, then 4 idle cycles, then a frame with data 1..8 on addr 0..7.
- Scroll wrap: msg_len=10, after 9 steps -> frame data 9,0,1,...,6; step 10 -> data 0..7 again.
- Short message: msg_len=3, msg={16,17,18} -> frame data 16,17,18,16,17,18,16,17.
- CPU priority: cpu_req for 2 cycles at digit 3 with addr 16'h0005, data 8'd12 -> two CPU writes of 12 to addr 5; the scroller resumes at digit 3; the frame completes 2 cycles late.
- Stop/start edge cases: stop at digit 4 -> no writes after that cycle, busy=0 next cycle; start with msg_len=0 -> busy stays 0. With BLANK_PAD_EN, msg_len=3 -> data 0,1,2,20,20,20,20,20.
